z80_bus_loader: RTL and testbench

//  Z80 bus initiator for the debug board: takes the bus via BUSRQ/BUSAK, then runs
//  Z80-style memory write/read cycles to fill or dump the cache SRAM and CPU-visible memory.

---
 rtl/z80_bus_loader_pkg.sv | 26 ++
 rtl/z80_bus_loader_sync2.sv | 26 ++
 rtl/z80_bus_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_z80_bus_loader.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_loader_pkg.sv
// Shared definitions for the Z80 bus loader.
//   state_t   : controller states (IDLE, REQ, SETUP, STROBE, HOLD, RELEASE)
//   OP_RD/WR  : transfer direction as latched from cmd_wr
//   PH_W      : width of the per-phase down-counter (PHASE_CLKS up to 15)
//   next_addr : 16-bit address step, wraps FFFF -> 0000
package z80_bus_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_SETUP   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_HOLD    = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int PH_W = 4;

    function automatic logic [15:0] next_addr(input logic [15:0] a);
        return a + 16'd1;
    endfunction

endpackage

// File: rtl/z80_bus_loader_sync2.sv
// Two-flop synchroniser for an asynchronous active-low Z80 input.
// Both flops preset to 1 so the synchronised signal reads "inactive" out of reset.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output
module z80_bus_loader_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/z80_bus_loader.sv
// Z80 bus initiator: requests the bus with BUSRQ/BUSAK, then runs memory write or
// read cycles (SETUP / STROBE / HOLD, PHASE_CLKS clocks each) to fill or dump memory.
// Tristate buffers live in the CPLD top; this block only produces bus_oe and d_oe.
//   clk, reset                      : clock, async active-low reset
//   cmd_start/wr/addr/len           : host command (accepted only when busy=0)
//   abort                           : finish the current bus cycle, then release
//   wd_data/wd_valid/wd_ready       : host write-data stream (wd_ready = consumed pulse)
//   rd_data/rd_valid/rd_ready       : host read-data stream (rd_valid held until rd_ready)
//   busy/done/error                 : status (error = sticky BUSAK timeout)
//   busrq_n/busak_n                 : Z80 bus request handshake
//   a_out/d_out/d_in/d_oe/bus_oe    : address/data bus and drive enables
//   mreq_n/rd_n/wr_n                : Z80 strobes
//
// state   | meaning
// IDLE    | waiting for cmd_start
// REQ     | busrq_n low, waiting for synchronised busak_n low (or timeout/abort)
// SETUP   | address driven; writes wait for host data, then PHASE_CLKS setup
// STROBE  | mreq_n plus rd_n or wr_n low for PHASE_CLKS
// HOLD    | strobes high, address/data held; reads wait for rd_ready
// RELEASE | bus released, waiting for busak_n to return high
module z80_bus_loader
    import z80_bus_loader_pkg::*;
#(
    parameter int PHASE_CLKS  = 2,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_wr,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic        abort,
    input  logic [7:0]  wd_data,
    input  logic        wd_valid,
    output logic        wd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic [15:0] a_out,
    output logic [7:0]  d_out,
    input  logic [7:0]  d_in,
    output logic        d_oe,
    output logic        bus_oe,
    output logic        mreq_n,
    output logic        rd_n,
    output logic        wr_n
);

    localparam int ACK_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [ACK_W-1:0] ACK_LOAD = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(PHASE_CLKS - 1);

    state_t            state;
    logic              op;
    logic [15:0]       addr;
    logic [15:0]       len;
    logic              abort_q;
    logic              have_data;
    logic              rd_taken;
    logic [ACK_W-1:0]  req_cnt;
    logic [PH_W-1:0]   ph_cnt;
    logic              busak_s;
    logic              abort_seen;
    logic              rd_hs;
    logic [15:0]       addr_nx;

    z80_bus_loader_sync2 u_busak_sync (
        .clk   (clk),
        .reset (reset),
        .d     (busak_n),
        .q     (busak_s)
    );

    // Abort acts even in the cycle it arrives, so a pulse coinciding with the
    // end of HOLD is not lost.
    assign abort_seen = abort_q | abort;
    assign rd_hs      = rd_valid & rd_ready;
    assign addr_nx    = next_addr(addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op        <= OP_RD;
            addr      <= '0;
            len       <= '0;
            abort_q   <= 1'b0;
            have_data <= 1'b0;
            rd_taken  <= 1'b0;
            req_cnt   <= '0;
            ph_cnt    <= '0;
            busrq_n   <= 1'b1;
            bus_oe    <= 1'b0;
            d_oe      <= 1'b0;
            mreq_n    <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            a_out     <= '0;
            d_out     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            wd_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            wd_ready <= 1'b0;
            done     <= 1'b0;
            if (state != ST_IDLE && abort)
                abort_q <= 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        error   <= 1'b0;
                        abort_q <= 1'b0;
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            op      <= cmd_wr;
                            addr    <= cmd_addr;
                            len     <= cmd_len;
                            busy    <= 1'b1;
                            busrq_n <= 1'b0;
                            req_cnt <= ACK_LOAD;
                            state   <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    if (!busak_s) begin
                        bus_oe    <= 1'b1;
                        a_out     <= addr;
                        have_data <= (op == OP_RD);
                        ph_cnt    <= PH_LOAD;
                        state     <= ST_SETUP;
                    end else if (abort_seen) begin
                        busrq_n <= 1'b1;
                        state   <= ST_RELEASE;
                    end else if (req_cnt == '0) begin
                        error   <= 1'b1;
                        busrq_n <= 1'b1;
                        state   <= ST_RELEASE;
                    end else begin
                        req_cnt <= req_cnt - ACK_W'(1);
                    end
                end

                ST_SETUP: begin
                    if (!have_data) begin
                        // Setup time is counted from when write data is on D.
                        if (wd_valid) begin
                            d_out     <= wd_data;
                            wd_ready  <= 1'b1;
                            d_oe      <= 1'b1;
                            have_data <= 1'b1;
                            ph_cnt    <= PH_LOAD;
                        end
                    end else if (ph_cnt == '0) begin
                        mreq_n <= 1'b0;
                        if (op == OP_WR)
                            wr_n <= 1'b0;
                        else
                            rd_n <= 1'b0;
                        ph_cnt <= PH_LOAD;
                        state  <= ST_STROBE;
                    end else begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                    end
                end

                ST_STROBE: begin
                    if (ph_cnt == '0) begin
                        mreq_n   <= 1'b1;
                        rd_n     <= 1'b1;
                        wr_n     <= 1'b1;
                        ph_cnt   <= PH_LOAD;
                        rd_taken <= 1'b0;
                        if (op == OP_RD) begin
                            rd_data  <= d_in;
                            rd_valid <= 1'b1;
                        end
                        state <= ST_HOLD;
                    end else begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (rd_hs) begin
                        rd_valid <= 1'b0;
                        rd_taken <= 1'b1;
                    end
                    if (ph_cnt != '0) begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                    end else if (op == OP_WR || rd_taken || rd_hs) begin
                        addr <= addr_nx;
                        len  <= len - 16'd1;
                        d_oe <= 1'b0;
                        if (len == 16'd1 || abort_seen) begin
                            bus_oe  <= 1'b0;
                            busrq_n <= 1'b1;
                            state   <= ST_RELEASE;
                        end else begin
                            a_out     <= addr_nx;
                            have_data <= (op == OP_RD);
                            ph_cnt    <= PH_LOAD;
                            state     <= ST_SETUP;
                        end
                    end
                end

                ST_RELEASE: begin
                    if (busak_s) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_loader.sv
// Scoreboard bench for z80_bus_loader: commands push expected bus cycles, read bytes
// and completions into queues; independent monitors pop and compare as the DUT
// presents strobes, rd handshakes and done pulses.
module tb_z80_bus_loader;

    localparam int PHASE  = 2;
    localparam int ACK_TO = 1023;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_start = 1'b0, cmd_wr = 1'b0;
    logic [15:0] cmd_addr = '0, cmd_len = '0;
    logic        abort = 1'b0;
    logic [7:0]  wd_data;
    logic        wd_valid;
    logic        wd_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        busy, done, error, busrq_n, busak_n;
    logic [15:0] a_out;
    logic [7:0]  d_out, d_in;
    logic        d_oe, bus_oe, mreq_n, rd_n, wr_n;

    always #5 clk = ~clk;

    z80_bus_loader #(.PHASE_CLKS(PHASE), .ACK_TIMEOUT(ACK_TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_start(cmd_start), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .abort(abort),
        .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done), .error(error),
        .busrq_n(busrq_n), .busak_n(busak_n),
        .a_out(a_out), .d_out(d_out), .d_in(d_in), .d_oe(d_oe), .bus_oe(bus_oe),
        .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n)
    );

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } cyc_t;

    int vectors = 0;
    int miscompares = 0;

    cyc_t       exp_cyc[$];
    logic [7:0] exp_rd[$];
    logic       exp_done[$];
    logic [7:0] wd_q[$];
    logic [7:0] fixed_q[$];
    logic [7:0] mem [0:65535];

    int ack_delay = 2;
    bit ack_stuck = 1'b0;
    int rd_lat = 0;
    int wd_gap_pct = 0;

    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int bus_oe_cnt = 0;
    int busrq_cnt = 0;

    assign d_in = mem[a_out];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ---------------- bus-side models ----------------
    initial begin : ack_model
        int n;
        n = 0;
        busak_n = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (busrq_n || ack_stuck) begin
                busak_n = 1'b1;
                n = 0;
            end else if (n >= ack_delay) begin
                busak_n = 1'b0;
            end else begin
                n++;
            end
        end
    end

    initial begin : wd_feed
        wd_valid = 1'b0;
        wd_data  = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (wd_ready && wd_valid && wd_q.size() > 0)
                void'(wd_q.pop_front());
            if (wd_q.size() > 0 && int'($urandom_range(99)) >= wd_gap_pct) begin
                wd_valid = 1'b1;
                wd_data  = wd_q[0];
            end else begin
                wd_valid = 1'b0;
                wd_data  = 8'($urandom);
            end
        end
    end

    initial begin : rd_drv
        int n;
        n = 0;
        rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rd_valid && !rd_ready) begin
                if (n >= rd_lat) rd_ready = 1'b1;
                else n++;
            end else begin
                rd_ready = 1'b0;
                n = 0;
            end
        end
    end

    // ---------------- monitors ----------------
    initial begin : bus_mon
        int slen, setup;
        logic [15:0] la, prev_a;
        logic lwr, lrd, loe, ldoe, prev_oe;
        logic [7:0] ld;
        cyc_t e;
        slen = 0; setup = 0; la = '0; prev_a = '0;
        lwr = 0; lrd = 0; loe = 0; ldoe = 0; prev_oe = 0; ld = '0;
        forever begin
            @(negedge clk);
            if (bus_oe) bus_oe_cnt++;
            if (!busrq_n) busrq_cnt++;
            if (!reset) begin
                slen = 0;
                setup = 0;
            end else if (!mreq_n) begin
                if (slen == 0) begin
                    la = a_out; lwr = !wr_n; lrd = !rd_n; ld = d_out;
                    loe = bus_oe; ldoe = d_oe;
                end
                slen++;
            end else if (slen != 0) begin
                if (exp_cyc.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_cycle: got cycle at %h wr=%0d, expected none", la, lwr);
                end else begin
                    e = exp_cyc.pop_front();
                    check("bus_cycle",
                          {lwr, lrd, la, (lwr ? ld : 8'h00), 8'(slen), loe, ldoe, (setup >= PHASE)},
                          {e.wr, !e.wr, e.addr, (e.wr ? e.data : 8'h00), 8'(PHASE), 1'b1, e.wr, 1'b1});
                end
                slen = 0;
                setup = 0;
            end else if (bus_oe && prev_oe && a_out == prev_a) begin
                setup++;
            end else begin
                setup = bus_oe ? 1 : 0;
            end
            prev_a = a_out;
            prev_oe = bus_oe;
        end
    end

    initial begin : rd_mon
        forever begin
            @(negedge clk);
            if (reset && rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rd: got %h, expected none", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_rd.pop_front());
                end
            end
        end
    end

    initial begin : done_mon
        logic e;
        forever begin
            @(negedge clk);
            if (reset && done) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_done.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done, expected none");
                end else begin
                    e = exp_done.pop_front();
                    check("done_status", {error, busy, busrq_n, bus_oe, d_oe},
                          {e, 1'b0, 1'b1, 1'b0, 1'b0});
                end
            end
        end
    end

    // ---------------- reference model / stimulus ----------------
    // A command of l bytes at a touches addresses a+i (mod 2^16); only the first
    // nbytes reach the bus (fewer when aborted or timed out).
    task automatic push_cmd(input logic wr, input logic [15:0] a, input int l,
                            input int nbytes, input logic err);
        cyc_t c;
        logic [7:0] b;
        for (int i = 0; i < l; i++) begin
            if (fixed_q.size() > 0) b = fixed_q.pop_front();
            else b = 8'($urandom);
            if (wr) wd_q.push_back(b);
            if (i < nbytes) begin
                c.wr = wr;
                c.addr = a + 16'(i);
                c.data = wr ? b : 8'h00;
                exp_cyc.push_back(c);
                if (!wr) exp_rd.push_back(mem[c.addr]);
            end
        end
        exp_done.push_back(err);
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] l);
        cmd_wr = wr;
        cmd_addr = a;
        cmd_len = l;
        cmd_start = 1'b1;
        start_cyc = cyc;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == d0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no done, required done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_strobe(input string name);
        int n;
        n = 0;
        while (mreq_n && n < 200) begin
            tick();
            n++;
        end
        if (mreq_n) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no strobe, required one within 200 cycles", name);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0, rq, oe, lat, l;
        logic wr;
        logic [15:0] a;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h3FFE] = 8'h12;
        mem[16'h3FFF] = 8'h34;

        tick(3);
        check("reset_outputs",
              {busrq_n, bus_oe, d_oe, mreq_n, rd_n, wr_n, a_out, d_out,
               busy, done, error, rd_valid, wd_ready},
              {6'b100111, 16'h0000, 8'h00, 5'b00000});
        reset = 1'b1;
        tick(3);

        // len = 0: done next cycle, bus never requested
        d0 = done_cnt;
        rq = busrq_cnt;
        push_cmd(1'b1, 16'h1234, 0, 0, 1'b0);
        issue(1'b1, 16'h1234, 16'd0);
        check("len0_done_next", {done, busy}, 2'b10);
        tick(4);
        check("len0_no_busrq", busrq_cnt - rq, 0);
        check("len0_done_count", done_cnt - d0, 1);

        // directed write
        ack_delay = 4;
        fixed_q = '{8'hAA, 8'h55, 8'hC3};
        d0 = done_cnt;
        push_cmd(1'b1, 16'h1000, 3, 3, 1'b0);
        issue(1'b1, 16'h1000, 16'd3);
        wait_done("write3", d0, 500);

        // directed read with late rd_ready
        rd_lat = 3;
        d0 = done_cnt;
        push_cmd(1'b0, 16'h3FFE, 2, 2, 1'b0);
        issue(1'b0, 16'h3FFE, 16'd2);
        wait_done("read2", d0, 500);
        rd_lat = 0;

        // address wrap
        d0 = done_cnt;
        push_cmd(1'b1, 16'hFFFF, 2, 2, 1'b0);
        issue(1'b1, 16'hFFFF, 16'd2);
        wait_done("wrap", d0, 500);

        // BUSAK timeout
        ack_stuck = 1'b1;
        d0 = done_cnt;
        oe = bus_oe_cnt;
        push_cmd(1'b0, 16'h2000, 4, 0, 1'b1);
        issue(1'b0, 16'h2000, 16'd4);
        wait_done("timeout", d0, ACK_TO + 200);
        lat = done_cyc - start_cyc;
        check("timeout_latency_ok", (lat >= ACK_TO && lat <= ACK_TO + 4), 1'b1);
        check("timeout_bus_oe_never", bus_oe_cnt - oe, 0);
        check("timeout_error_sticky", {error, busrq_n}, 2'b11);
        ack_stuck = 1'b0;
        tick(3);

        // abort during first strobe of a 10-byte write; error clears on accept
        d0 = done_cnt;
        push_cmd(1'b1, 16'h5000, 10, 1, 1'b0);
        issue(1'b1, 16'h5000, 16'd10);
        check("error_cleared", error, 1'b0);
        wait_strobe("abort_strobe");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("abort", d0, 500);
        wd_q.delete();
        tick(3);

        // reset in the middle of a write strobe
        for (int i = 0; i < 3; i++) wd_q.push_back(8'($urandom));
        issue(1'b1, 16'h4000, 16'd3);
        wait_strobe("reset_strobe");
        reset = 1'b0;
        #1;
        check("reset_mid_strobe", {bus_oe, d_oe, mreq_n, wr_n, rd_n, busrq_n, busy},
              7'b0011110);
        wd_q.delete();
        tick(2);
        reset = 1'b1;
        tick(10);
        check("idle_after_reset", {busy, busrq_n, bus_oe}, 3'b010);

        // randomized commands
        for (int k = 0; k < 25; k++) begin
            wr = 1'($urandom);
            a = ($urandom_range(3) == 0) ? 16'hFFFD + 16'($urandom_range(2)) : 16'($urandom);
            l = $urandom_range(1, 5);
            ack_delay = $urandom_range(0, 6);
            rd_lat = $urandom_range(0, 4);
            wd_gap_pct = $urandom_range(0, 60);
            d0 = done_cnt;
            push_cmd(wr, a, l, l, 1'b0);
            issue(wr, a, 16'(l));
            tick(2);
            if (busy && k[0]) begin
                // must be ignored while a command is in progress
                cmd_wr = ~wr;
                cmd_addr = 16'($urandom);
                cmd_len = 16'd7;
                cmd_start = 1'b1;
                tick();
                cmd_start = 1'b0;
            end
            wait_done("random_cmd", d0, 600);
            tick($urandom_range(0, 3));
        end

        tick(5);
        check("queues_drained", exp_cyc.size() + exp_rd.size() + exp_done.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
